// File: rtl/blink_rate_detector.sv
// Measures the half-period of an asynchronous blink signal and locks onto one of
// five nominal blink rates once two consecutive measurements agree.
module blink_rate_detector #(
  parameter int unsigned n_clks_1hz     = 25000000,
  parameter int unsigned n_clks_2hz     = 12500000,
  parameter int unsigned n_clks_3hz     = 8333333,
  parameter int unsigned n_clks_5hz     = 5000000,
  parameter int unsigned n_clks_10hz    = 2500000,
  parameter int unsigned n_tol          = 1000,
  parameter int unsigned n_clks_timeout = 50000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sig,
  output logic [25:0] o_period,
  output logic        o_valid,
  output logic [2:0]  o_rate,
  output logic        o_locked,
  output logic        o_timeout,
  output logic        o_state_dbg
);

  // o_valid is a one-cycle strobe with no back-pressure: o_period, o_rate and
  // o_locked all take their new values on the cycle it is high and hold after.

  typedef enum logic {WAIT_FIRST = 1'b0, MEASURE = 1'b1} state_t;

  localparam logic [25:0] C1  = 26'(n_clks_1hz + 1);
  localparam logic [25:0] C2  = 26'(n_clks_2hz + 1);
  localparam logic [25:0] C3  = 26'(n_clks_3hz + 1);
  localparam logic [25:0] C5  = 26'(n_clks_5hz + 1);
  localparam logic [25:0] C10 = 26'(n_clks_10hz + 1);
  localparam logic [26:0] TOL = 27'(n_tol);
  localparam logic [25:0] TMO = 26'(n_clks_timeout);

  state_t      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic        sig_edge;
  logic [25:0] ctr_q, ctr_d;
  logic [25:0] period_q, period_d;
  logic        valid_q, valid_d;
  logic [2:0]  rate_q, rate_d;
  logic        locked_q, locked_d;
  logic        timeout_q, timeout_d;
  logic [2:0]  prev_q, prev_d;
  logic [2:0]  cls;

  assign sig_edge = s2_q ^ s3_q;

  // One bit of headroom so m + tol and c + tol cannot wrap.
  function automatic logic near(input logic [25:0] m, input logic [25:0] c);
    near = (({1'b0, m} + TOL) >= {1'b0, c}) && ({1'b0, m} <= ({1'b0, c} + TOL));
  endfunction

  always_comb begin
    cls = 3'd0;
    if      (near(ctr_q, C1))  cls = 3'd1;
    else if (near(ctr_q, C2))  cls = 3'd2;
    else if (near(ctr_q, C3))  cls = 3'd3;
    else if (near(ctr_q, C5))  cls = 3'd4;
    else if (near(ctr_q, C10)) cls = 3'd5;
  end

  always_comb begin
    state_d   = state_q;
    ctr_d     = sig_edge ? 26'd1 : ((ctr_q == TMO) ? ctr_q : ctr_q + 26'd1);
    period_d  = period_q;
    valid_d   = 1'b0;
    rate_d    = rate_q;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    prev_d    = prev_q;
    case (state_q)
      WAIT_FIRST: begin
        if (sig_edge) begin
          state_d   = MEASURE;
          timeout_d = 1'b0;
        end
      end
      MEASURE: begin
        if (sig_edge) begin
          period_d = ctr_q;
          valid_d  = 1'b1;
          prev_d   = cls;
          if (cls != 3'd0 && cls == prev_q) begin
            rate_d   = cls;
            locked_d = 1'b1;
          end else begin
            rate_d   = 3'd0;
            locked_d = 1'b0;
          end
        end else if (ctr_q == TMO) begin
          state_d   = WAIT_FIRST;
          timeout_d = 1'b1;
          rate_d    = 3'd0;
          locked_d  = 1'b0;
          prev_d    = 3'd0;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= WAIT_FIRST;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      ctr_q     <= 26'd0;
      period_q  <= 26'd0;
      valid_q   <= 1'b0;
      rate_q    <= 3'd0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      prev_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      s1_q      <= i_sig;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      ctr_q     <= ctr_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      rate_q    <= rate_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      prev_q    <= prev_d;
    end
  end

  assign o_period    = period_q;
  assign o_valid     = valid_q;
  assign o_rate      = rate_q;
  assign o_locked    = locked_q;
  assign o_timeout   = timeout_q;
  assign o_state_dbg = state_q;

endmodule
